// File: rtl/spi_m_tx.sv
// SPI master transmitter, mode 0 (CPOL=0, CPHA=0), MSB first.
// Words arrive over a valid/ready handshake. NSS stays low across a burst
// until a word tagged last has been shifted out and a trailing half-period has elapsed.
module spi_m_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_last,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_spi_clk,
    output logic                  o_spi_mosi,
    output logic                  o_spi_nss
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StShift,
        StWait,
        StTrail
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  last_q, last_d;
    logic                  nss_q, nss_d;
    logic                  sclk_q, sclk_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  cnt_zero;

    // Ready is only meaningful in IDLE/WAIT and is forced low while reset is held.
    assign o_tx_ready = ~i_reset & ((state_q == StIdle) | (state_q == StWait));
    assign accept     = i_tx_valid & o_tx_ready;
    assign cnt_zero   = (cnt_q == '0);

    assign o_busy     = (state_q != StIdle);
    assign o_done     = done_q;
    assign o_spi_clk  = sclk_q;
    assign o_spi_nss  = nss_q;
    // The shift register MSB is the line; it is cleared at frame end so MOSI idles low.
    assign o_spi_mosi = shreg_q[DATA_WIDTH-1];

    // Next-state logic: sequencing of NSS lead, SCLK half-periods and trailing delay.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        nss_d   = nss_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StLead;
                    nss_d   = 1'b0;
                    shreg_d = i_tx_data;
                    last_d  = i_tx_last;
                    cnt_d   = CNT_RELOAD;
                end
            end
            StLead: begin
                if (cnt_zero) begin
                    state_d = StShift;
                    sclk_d  = 1'b1;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StShift: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sclk_q) begin
                    // Falling edge: present the next bit, except after the last one.
                    sclk_d = 1'b0;
                    cnt_d  = CNT_RELOAD;
                    if (bit_q != BIT_LAST) begin
                        shreg_d = shreg_q << 1;
                    end
                end else begin
                    cnt_d = CNT_RELOAD;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = last_q ? StTrail : StWait;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (accept) begin
                    state_d = StLead;
                    shreg_d = i_tx_data;
                    last_d  = i_tx_last;
                    cnt_d   = CNT_RELOAD;
                end
            end
            StTrail: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                    nss_d   = 1'b1;
                    shreg_d = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any transfer in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
            nss_q   <= 1'b1;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            nss_q   <= nss_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_m_tx.sv
// Bench for spi_m_tx: directed stimulus, with a scoreboard-driven serial monitor acting as the slave.
module tb_spi_m_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CLK_DIV=4
    logic       rst_a, last_a, valid_a, ready_a, busy_a, done_a, sclk_a, mosi_a, nss_a;
    logic [7:0] d_a;
    // Instance B: CLK_DIV=1
    logic       rst_b, last_b, valid_b, ready_b, busy_b, done_b, sclk_b, mosi_b, nss_b;
    logic [7:0] d_b;

    spi_m_tx #(.CLK_DIV(4), .DATA_WIDTH(8)) u_dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_tx_data(d_a), .i_tx_last(last_a),
        .i_tx_valid(valid_a), .o_tx_ready(ready_a), .o_busy(busy_a), .o_done(done_a),
        .o_spi_clk(sclk_a), .o_spi_mosi(mosi_a), .o_spi_nss(nss_a)
    );

    spi_m_tx #(.CLK_DIV(1), .DATA_WIDTH(8)) u_dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_tx_data(d_b), .i_tx_last(last_b),
        .i_tx_valid(valid_b), .o_tx_ready(ready_b), .o_busy(busy_b), .o_done(done_b),
        .o_spi_clk(sclk_b), .o_spi_mosi(mosi_b), .o_spi_nss(nss_b)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         frm_a[$];
    int         frm_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    // Monitor state, index 0 = A, 1 = B
    logic       sp[2];
    logic       np[2];
    logic       rp[2];
    int         nbit[2];
    int         nword[2];
    int         nrise[2];
    logic [7:0] sh[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            sp[i] = 1'b0; np[i] = 1'b1; rp[i] = 1'b1;
            nbit[i] = 0; nword[i] = 0; nrise[i] = 0; sh[i] = '0;
        end
    end

    task automatic mon(input int id, input logic rst, input logic sclk, input logic nss,
                       input logic mosi, input logic done, input logic busy);
        logic [7:0] w;
        int         f;
        if (rst) begin
            nbit[id] = 0; nword[id] = 0; nrise[id] = 0;
        end else begin
            if (sclk && !sp[id]) begin
                check("sclk_rise_with_nss_high", {31'd0, nss}, 32'd0);
                sh[id] = {sh[id][6:0], mosi};
                nbit[id]++;
                nrise[id]++;
                if (nbit[id] == 8) begin
                    nbit[id] = 0;
                    nword[id]++;
                    if ((id == 0 && exp_a.size() == 0) || (id == 1 && exp_b.size() == 0)) begin
                        total++; bad++;
                        $display("FAIL word%0d: got %h required none", id, sh[id]);
                    end else begin
                        w = (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
                        check("word", {24'd0, sh[id]}, {24'd0, w});
                    end
                end
            end
            if (nss && !np[id] && !rp[id]) check("done_at_nss_rise", {31'd0, done}, 32'd1);
            if (done) begin
                check("busy_during_done", {31'd0, busy}, 32'd0);
                if ((id == 0 && frm_a.size() == 0) || (id == 1 && frm_b.size() == 0)) begin
                    total++; bad++;
                    $display("FAIL frame%0d: got done required none", id);
                end else begin
                    f = (id == 0) ? frm_a.pop_front() : frm_b.pop_front();
                    check("frame_words", nword[id], f);
                    check("frame_rises", nrise[id], 8 * f);
                end
                nword[id] = 0; nrise[id] = 0; nbit[id] = 0;
            end
        end
        sp[id] = sclk; np[id] = nss; rp[id] = rst;
    endtask

    // Sample well after each rising edge
    always @(posedge clk) begin
        #2;
        mon(0, rst_a, sclk_a, nss_a, mosi_a, done_a, busy_a);
        mon(1, rst_b, sclk_b, nss_b, mosi_b, done_b, busy_b);
    end

    // Called at a negedge; returns at the negedge of cycle 1 after acceptance.
    task automatic send_a(input logic [7:0] d, input logic l, input bit push);
        int n = 0;
        d_a = d; last_a = l; valid_a = 1'b1;
        while (!ready_a && n < 2000) begin @(negedge clk); n++; end
        if (!ready_a) fail_now("send_a_ready");
        @(posedge clk);
        if (push) exp_a.push_back(d);
        @(negedge clk);
    endtask

    task automatic wait_idle_a(input string name, output int dones);
        int n = 0;
        dones = 0;
        while (busy_a && n < 2000) begin
            if (done_a) dones++;
            @(negedge clk);
            n++;
        end
        if (busy_a) fail_now(name);
        if (done_a) dones++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] pat;
    int         e_nss, e_sclk, e_mosi, e_rdy, done_cyc, dones, n;
    int         rise_cnt, first_rise, last_rise;
    logic       xs, xm, prev_s;
    int         idx;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        d_a = '0; d_b = '0; last_a = 1'b0; last_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready_a}, 0);
        check("rst_nss", {31'd0, nss_a}, 1);
        check("rst_sclk_mosi", {30'd0, sclk_a, mosi_a}, 0);
        check("rst_busy_done", {30'd0, busy_a, done_a}, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, ready_a}, 1);

        // 1: single word 0xA5, full cycle-accurate trace
        pat = 8'hA5;
        frm_a.push_back(1);
        send_a(8'hA5, 1'b1, 1'b1);
        valid_a = 1'b0;
        e_nss = 0; e_sclk = 0; e_mosi = 0; e_rdy = 0; done_cyc = -1;
        for (int k = 1; k <= 80; k++) begin
            xs  = (k >= 5) && (k <= 68) && (((k - 5) % 8) < 4);
            idx = (k - 1) / 8;
            if (idx > 7) idx = 7;
            xm  = (k <= 72) ? pat[7 - idx] : 1'b0;
            if (nss_a !== (k > 72)) e_nss++;
            if (sclk_a !== xs) e_sclk++;
            if (mosi_a !== xm) e_mosi++;
            if (ready_a !== (k >= 73)) e_rdy++;
            if (done_a === 1'b1 && done_cyc < 0) done_cyc = k;
            @(negedge clk);
        end
        check("t1_nss_trace_errs", e_nss, 0);
        check("t1_sclk_trace_errs", e_sclk, 0);
        check("t1_mosi_trace_errs", e_mosi, 0);
        check("t1_ready_trace_errs", e_rdy, 0);
        check("t1_done_cycle", done_cyc, 73);

        // 2: burst with valid held high
        frm_a.push_back(3);
        send_a(8'h3C, 1'b0, 1'b1);
        send_a(8'hFF, 1'b0, 1'b1);
        send_a(8'h01, 1'b1, 1'b1);
        valid_a = 1'b0;
        wait_idle_a("t2_idle", dones);
        check("t2_done_pulses", dones, 1);
        repeat (3) @(negedge clk);

        // 3: valid gap leaves the master parked in WAIT
        frm_a.push_back(2);
        send_a(8'h96, 1'b0, 1'b1);
        valid_a = 1'b0;
        n = 0;
        while (!(busy_a && ready_a) && n < 500) begin @(negedge clk); n++; end
        if (!(busy_a && ready_a)) fail_now("t3_wait_entry");
        e_nss = 0;
        for (int k = 0; k < 20; k++) begin
            if (nss_a !== 1'b0 || sclk_a !== 1'b0 || ready_a !== 1'b1 || mosi_a !== 1'b0) e_nss++;
            @(negedge clk);
        end
        check("t3_wait_hold_errs", e_nss, 0);
        send_a(8'hE9, 1'b1, 1'b1);
        valid_a = 1'b0;
        check("t3_lead_mosi_msb", {31'd0, mosi_a}, 1);
        check("t3_lead_ready", {31'd0, ready_a}, 0);
        e_sclk = 0;
        for (int k = 1; k <= 5; k++) begin
            if (sclk_a !== (k == 5) || nss_a !== 1'b0) e_sclk++;
            @(negedge clk);
        end
        check("t3_restart_timing_errs", e_sclk, 0);
        wait_idle_a("t3_idle", dones);
        check("t3_done_pulses", dones, 1);
        repeat (3) @(negedge clk);

        // 4: reset during 0x5A at cycle 30
        send_a(8'h5A, 1'b1, 1'b0);
        valid_a = 1'b0;
        repeat (29) @(negedge clk);
        check("t4_pre_reset_mosi_sclk", {30'd0, sclk_a, mosi_a}, 3);
        rst_a = 1'b1;
        #1;
        check("t4_ready_in_reset", {31'd0, ready_a}, 0);
        @(negedge clk);
        check("t4_nss", {31'd0, nss_a}, 1);
        check("t4_sclk_mosi", {30'd0, sclk_a, mosi_a}, 0);
        check("t4_ready_busy", {30'd0, ready_a, busy_a}, 0);
        rst_a = 1'b0;
        @(negedge clk);
        check("t4_ready_after", {31'd0, ready_a}, 1);
        e_sclk = 0;
        for (int k = 0; k < 20; k++) begin
            if (sclk_a !== 1'b0 || nss_a !== 1'b1) e_sclk++;
            @(negedge clk);
        end
        check("t4_quiet_errs", e_sclk, 0);

        // 6: back-to-back frames, valid high through the done cycle
        frm_a.push_back(1);
        frm_a.push_back(1);
        send_a(8'h11, 1'b1, 1'b1);
        d_a = 8'h22;
        n = 0;
        while (!done_a && n < 500) begin @(negedge clk); n++; end
        if (!done_a) fail_now("t6_done");
        check("t6_done_nss_ready", {30'd0, nss_a, ready_a}, 3);
        @(posedge clk);
        exp_a.push_back(8'h22);
        @(negedge clk);
        valid_a = 1'b0;
        check("t6_nss_high_one_cycle", {31'd0, nss_a}, 0);
        check("t6_busy_again", {31'd0, busy_a}, 1);
        wait_idle_a("t6_idle", dones);
        check("t6_done_pulses", dones, 1);

        // 5: CLK_DIV=1 on instance B
        frm_b.push_back(1);
        d_b = 8'h81; last_b = 1'b1; valid_b = 1'b1;
        n = 0;
        while (!ready_b && n < 100) begin @(negedge clk); n++; end
        if (!ready_b) fail_now("t5_ready");
        @(posedge clk);
        exp_b.push_back(8'h81);
        @(negedge clk);
        valid_b = 1'b0;
        rise_cnt = 0; first_rise = -1; last_rise = -1; done_cyc = -1; e_sclk = 0;
        prev_s = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (sclk_b !== ((k >= 2) && (k <= 17) && (k % 2 == 0))) e_sclk++;
            if (sclk_b === 1'b1 && !prev_s) begin
                rise_cnt++;
                if (first_rise < 0) first_rise = k;
                last_rise = k;
            end
            prev_s = sclk_b;
            if (done_b === 1'b1 && done_cyc < 0) done_cyc = k;
            @(negedge clk);
        end
        check("t5_sclk_trace_errs", e_sclk, 0);
        check("t5_rises", rise_cnt, 8);
        check("t5_first_rise", first_rise, 2);
        check("t5_last_rise", last_rise, 16);
        check("t5_done_cycle", done_cyc, 19);

        repeat (5) @(negedge clk);
        check("a_words_left", exp_a.size(), 0);
        check("a_frames_left", frm_a.size(), 0);
        check("b_words_left", exp_b.size(), 0);
        check("b_frames_left", frm_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
